// File: rtl/reductor_arbiter.sv
// reductor_arbiter
//   Round-robin arbiter that serializes wide input words into narrow beats.
//   A granted word of NO chunks leaves on dout as NO consecutive beats, chunk 0
//   first. The grant stays locked until the last beat, and the input is acked
//   only on that last beat.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   din_data   : [NUM] input words, NO*W_DATA bits each; chunk i = [i*W_DATA +: W_DATA]
//   din_valid  : [NUM] input valids
//   din_ready  : [NUM] input readies (pulse on last-beat handshake only)
//   dout_data  : {src[SW-1:0], last, chunk[W_DATA-1:0]}
//   dout_valid : output valid
//   dout_ready : output ready
//
// state | meaning
// IDLE  | no grant locked; chunk 0 of the round-robin pick shown combinationally
// BUSY  | grant locked to g; chunk cnt of din[g] shown
module reductor_arbiter #(
    parameter int W_DATA = 16,
    parameter int NO     = 4,
    parameter int NUM    = 2,
    localparam int SW    = ($clog2(NUM) > 1) ? $clog2(NUM) : 1,
    localparam int CW    = ($clog2(NO) > 1) ? $clog2(NO) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM-1:0][NO*W_DATA-1:0]    din_data,
    input  logic [NUM-1:0]                   din_valid,
    output logic [NUM-1:0]                   din_ready,
    output logic [W_DATA+SW:0]               dout_data,
    output logic                             dout_valid,
    input  logic                             dout_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [SW-1:0]       ptr, ptr_n, g, g_n;
    logic [SW-1:0]       sel, cur;
    logic                found, cur_valid, last, hs;
    logic [NO*W_DATA-1:0] word;
    logic [W_DATA-1:0]   chunk;
    int                  idx;

    // Explicit wrap so non-power-of-2 NUM never reaches an unused index.
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
        if (int'(x) >= NUM - 1)
            return '0;
        else
            return x + SW'(1);
    endfunction

    // First valid input at or after ptr, wrapping modulo NUM.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM)
                idx = idx - NUM;
            if (!found && din_valid[idx]) begin
                sel   = SW'(idx);
                found = 1'b1;
            end
        end
    end

    assign cur = (state == BUSY) ? g : sel;

    always_comb begin
        word      = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (cur == SW'(i)) begin
                word      = din_data[i];
                cur_valid = din_valid[i];
            end
        end
    end

    // cnt is zero in IDLE, so one mux serves both states.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < NO; i++) begin
            if (int'(cnt) == i)
                chunk = word[i*W_DATA +: W_DATA];
        end
    end

    assign last = (int'(cnt) == NO - 1);

    // In BUSY only the locked input counts; a dropped valid there stalls the
    // burst without releasing the lock.
    always_comb begin
        dout_valid = 1'b0;
        if (!rst)
            dout_valid = (state == IDLE) ? (|din_valid) : cur_valid;
    end

    assign hs        = dout_valid && dout_ready;
    assign dout_data = {cur, last, chunk};

    always_comb begin
        din_ready = '0;
        for (int i = 0; i < NUM; i++)
            din_ready[i] = hs && last && (cur == SW'(i));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        g_n     = g;
        if (hs) begin
            if (last) begin
                state_n = IDLE;
                cnt_n   = '0;
                ptr_n   = wrap_inc(cur);
            end else begin
                state_n = BUSY;
                cnt_n   = cnt + CW'(1);
                if (state == IDLE)
                    g_n = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            g     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            g     <= g_n;
        end
    end

endmodule

// File: tb/tb_reductor_arbiter.sv
// tb_reductor_arbiter
//   Directed bench for reductor_arbiter: one instance with W_DATA=8, NO=4,
//   NUM=3 and one with W_DATA=8, NO=1, NUM=3. Expected beats are hand-derived
//   from the input words.
module tb_reductor_arbiter;

    logic clk;
    logic rst;

    logic [2:0][31:0] a_din_data;
    logic [2:0]       a_din_valid;
    logic [2:0]       a_din_ready;
    logic [10:0]      a_dout_data;
    logic             a_dout_valid;
    logic             a_dout_ready;

    logic [2:0][7:0]  b_din_data;
    logic [2:0]       b_din_valid;
    logic [2:0]       b_din_ready;
    logic [10:0]      b_dout_data;
    logic             b_dout_valid;
    logic             b_dout_ready;

    int checks;
    int failures;

    reductor_arbiter #(.W_DATA(8), .NO(4), .NUM(3)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_data   (a_din_data),
        .din_valid  (a_din_valid),
        .din_ready  (a_din_ready),
        .dout_data  (a_dout_data),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready)
    );

    reductor_arbiter #(.W_DATA(8), .NO(1), .NUM(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_data   (b_din_data),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .dout_data  (b_dout_data),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input logic v, input logic [1:0] s,
                          input logic l, input logic [7:0] c, input logic [2:0] r);
        chk({tag, ".valid"}, 32'(a_dout_valid), 32'(v));
        chk({tag, ".ready"}, 32'(a_din_ready), 32'(r));
        if (v) begin
            chk({tag, ".src"},   32'(a_dout_data[10:9]), 32'(s));
            chk({tag, ".last"},  32'(a_dout_data[8]),    32'(l));
            chk({tag, ".chunk"}, 32'(a_dout_data[7:0]),  32'(c));
        end
    endtask

    task automatic beat_b(input string tag, input logic [1:0] s, input logic [7:0] c,
                          input logic [2:0] r);
        chk({tag, ".valid"}, 32'(b_dout_valid),      32'd1);
        chk({tag, ".src"},   32'(b_dout_data[10:9]), 32'(s));
        chk({tag, ".last"},  32'(b_dout_data[8]),    32'd1);
        chk({tag, ".chunk"}, 32'(b_dout_data[7:0]),  32'(c));
        chk({tag, ".ready"}, 32'(b_din_ready),       32'(r));
    endtask

    initial begin
        logic [1:0] src_seq [4];
        logic [1:0] es;
        int         k;
        logic [31:0] w;

        checks   = 0;
        failures = 0;
        src_seq  = '{2'd0, 2'd1, 2'd2, 2'd0};

        rst          = 1'b1;
        a_din_data[0] = 32'hDDCCBBAA;
        a_din_data[1] = 32'h44332211;
        a_din_data[2] = 32'h88776655;
        a_din_valid  = 3'b010;
        a_dout_ready = 1'b1;
        b_din_data[0] = 8'hA0;
        b_din_data[1] = 8'hB1;
        b_din_data[2] = 8'hC2;
        b_din_valid  = 3'b000;
        b_dout_ready = 1'b1;

        // Reset holds outputs quiet even with a valid input.
        tick();
        beat_a("rst_hold0", 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        tick();
        beat_a("rst_hold1", 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);

        // Single input burst.
        rst = 1'b0;
        #1;
        beat_a("solo_b0", 1'b1, 2'd1, 1'b0, 8'h11, 3'b000);
        tick();
        beat_a("solo_b1", 1'b1, 2'd1, 1'b0, 8'h22, 3'b000);
        tick();
        beat_a("solo_b2", 1'b1, 2'd1, 1'b0, 8'h33, 3'b000);
        tick();
        beat_a("solo_b3", 1'b1, 2'd1, 1'b1, 8'h44, 3'b010);
        tick();
        a_din_valid = 3'b111;
        #1;
        beat_a("solo_ptr2", 1'b1, 2'd2, 1'b0, 8'h55, 3'b000);

        // All inputs valid after reset: grants 0,1,2,0 back to back.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int b = 0; b < 12; b++) begin
            es = src_seq[b / 4];
            k  = b % 4;
            w  = a_din_data[es];
            beat_a($sformatf("rr_beat%0d", b), 1'b1, es, (k == 3), w[8*k +: 8],
                   (k == 3) ? (3'b001 << es) : 3'b000);
            tick();
        end

        // No preemption of a burst in progress.
        rst = 1'b1;
        a_din_valid = 3'b100;
        tick();
        rst = 1'b0;
        #1;
        beat_a("nopre_b0", 1'b1, 2'd2, 1'b0, 8'h55, 3'b000);
        tick();
        a_din_valid = 3'b101;
        #1;
        beat_a("nopre_b1", 1'b1, 2'd2, 1'b0, 8'h66, 3'b000);
        tick();
        beat_a("nopre_b2", 1'b1, 2'd2, 1'b0, 8'h77, 3'b000);
        tick();
        beat_a("nopre_b3", 1'b1, 2'd2, 1'b1, 8'h88, 3'b100);
        tick();
        beat_a("nopre_next", 1'b1, 2'd0, 1'b0, 8'hAA, 3'b000);

        // Backpressure at cnt=2.
        rst = 1'b1;
        a_din_valid = 3'b010;
        tick();
        rst = 1'b0;
        #1;
        beat_a("bp_b0", 1'b1, 2'd1, 1'b0, 8'h11, 3'b000);
        tick();
        beat_a("bp_b1", 1'b1, 2'd1, 1'b0, 8'h22, 3'b000);
        tick();
        a_dout_ready = 1'b0;
        #1;
        beat_a("bp_stall0", 1'b1, 2'd1, 1'b0, 8'h33, 3'b000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            beat_a($sformatf("bp_stall%0d", i), 1'b1, 2'd1, 1'b0, 8'h33, 3'b000);
        end
        a_dout_ready = 1'b1;
        #1;
        beat_a("bp_resume", 1'b1, 2'd1, 1'b0, 8'h33, 3'b000);
        tick();
        beat_a("bp_last", 1'b1, 2'd1, 1'b1, 8'h44, 3'b010);

        // Reset mid-burst abandons the word without an ack.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        beat_a("mid_b0", 1'b1, 2'd1, 1'b0, 8'h11, 3'b000);
        tick();
        beat_a("mid_b1", 1'b1, 2'd1, 1'b0, 8'h22, 3'b000);
        tick();
        rst = 1'b1;
        #1;
        beat_a("mid_rst0", 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        tick();
        beat_a("mid_rst1", 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        rst = 1'b0;
        #1;
        beat_a("mid_restart", 1'b1, 2'd1, 1'b0, 8'h11, 3'b000);

        // NO=1 instance: every beat is last, ptr advances each beat.
        a_din_valid = 3'b000;
        b_din_valid = 3'b101;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        beat_a("a_quiet", 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        beat_b("single0", 2'd0, 8'hA0, 3'b001);
        tick();
        beat_b("single1", 2'd2, 8'hC2, 3'b100);
        tick();
        beat_b("single2", 2'd0, 8'hA0, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
